// File: rtl/entropy_overlay_pkg.sv
// Shared encodings and the NORMAL-state decision for the multi-channel entropy overlay.
package entropy_overlay_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_STALL  = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_LOCK   = 2'b11
    } ovl_state_e;

    localparam logic [1:0] ML_OK    = 2'b00;
    localparam logic [1:0] ML_STALL = 2'b01;
    localparam logic [1:0] ML_FLUSH = 2'b10;
    localparam logic [1:0] ML_LOCK  = 2'b11;

    localparam logic [1:0] LVL_LOW      = 2'b00;
    localparam logic [1:0] LVL_MID      = 2'b01;
    localparam logic [1:0] LVL_CRITICAL = 2'b10;
    localparam logic [1:0] LVL_RSVD     = 2'b11;

    localparam logic [2:0] IT_LOAD   = 3'b001;
    localparam logic [2:0] IT_STORE  = 3'b010;
    localparam logic [2:0] IT_BRANCH = 3'b011;
    localparam logic [2:0] IT_JUMP   = 3'b100;

    localparam logic [1:0] MIS_HIGH_THREAT = 2'b01;
    localparam logic [1:0] MIS_DIAGNOSTIC  = 2'b10;

    // DIAGNOSTIC missions never lock on local evidence; such requests degrade to FLUSH.
    function automatic ovl_state_e diag_cap(input ovl_state_e ns, input logic [1:0] mission);
        return (mission == MIS_DIAGNOSTIC && ns == ST_LOCK) ? ST_FLUSH : ns;
    endfunction

    function automatic ovl_state_e normal_decision(
        input logic [1:0] ml,
        input logic       hazard,
        input logic [1:0] level,
        input logic       over_thr,
        input logic [2:0] itype,
        input logic [1:0] mission
    );
        ovl_state_e ns;
        logic       ht;
        ht = (mission == MIS_HIGH_THREAT);
        ns = ST_NORMAL;
        if (ml == ML_STALL)
            ns = ST_STALL;
        else if (ml == ML_FLUSH)
            ns = ST_FLUSH;
        else if (ml == ML_LOCK)
            ns = ST_LOCK;
        else if (hazard)
            ns = ST_STALL;
        else if (level == LVL_CRITICAL)
            ns = ht ? ST_LOCK : ST_FLUSH;
        else if (over_thr)
            ns = ht ? ST_FLUSH : ST_STALL;
        else if (level == LVL_MID || level == LVL_RSVD) begin
            if (itype == IT_BRANCH || itype == IT_JUMP)
                ns = ST_STALL;
            else if (itype == IT_LOAD || itype == IT_STORE)
                ns = ht ? ST_FLUSH : ST_STALL;
        end
        return diag_cap(ns, mission);
    endfunction

endpackage

// File: rtl/entropy_overlay_channel.sv
// One NORMAL/STALL/FLUSH/LOCK controller with its clear-hold and stall-timeout counters.
module entropy_overlay_channel
    import entropy_overlay_pkg::*;
#(
    parameter int ENT_W               = 8,
    parameter int HOLD_CYCLES         = 4,
    parameter int STALL_TIMEOUT       = 32,
    parameter int LOCK_RELEASE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ml_action,
    input  logic [ENT_W-1:0] score,
    input  logic             hazard,
    input  logic [1:0]       level,
    input  logic [2:0]       itype,
    input  logic             shock,
    input  logic             quantum_override,
    input  logic             lock_req,
    input  logic             flush_req,
    input  logic [1:0]       mission,
    input  logic [ENT_W-1:0] threshold,
    input  logic             lock_clear_ack,
    input  logic             global_lock,
    output ovl_state_e       state,
    output ovl_state_e       state_next
);

    localparam int HOLD_MAX = (HOLD_CYCLES > LOCK_RELEASE_CYCLES) ? HOLD_CYCLES : LOCK_RELEASE_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int STALL_W  = $clog2(STALL_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_SAT   = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  REL_LAST   = HOLD_W'(LOCK_RELEASE_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

    ovl_state_e         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               over_thr, clear, ht;

    always_comb begin
        over_thr = (score > threshold);
        clear    = (ml_action == ML_OK) && !hazard && (level == LVL_LOW) && !over_thr && !shock;
        ht       = (mission == MIS_HIGH_THREAT);
        state_d  = state_q;

        if (quantum_override || lock_req)
            state_d = ST_LOCK;
        else if (flush_req)
            state_d = (state_q == ST_LOCK) ? ST_LOCK : ST_FLUSH;
        else if (shock) begin
            case (state_q)
                ST_NORMAL: state_d = ST_FLUSH;
                ST_LOCK:   state_d = ST_LOCK;
                default:   state_d = diag_cap(ST_LOCK, mission);
            endcase
        end else if (global_lock)
            state_d = ST_LOCK;
        else begin
            case (state_q)
                ST_NORMAL:
                    state_d = normal_decision(ml_action, hazard, level, over_thr, itype, mission);
                ST_STALL: begin
                    if (ml_action == ML_FLUSH || ml_action == ML_LOCK)
                        state_d = diag_cap(ovl_state_e'(ml_action), mission);
                    else if (clear && hold_q >= HOLD_LAST)
                        state_d = ST_NORMAL;
                    else if (stall_q >= STALL_LAST)
                        state_d = ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (ml_action == ML_LOCK)
                        state_d = diag_cap(ST_LOCK, mission);
                    else if (ml_action == ML_STALL)
                        state_d = ST_STALL;
                    else if (clear && hold_q >= HOLD_LAST)
                        state_d = ST_NORMAL;
                end
                default: begin
                    if (clear && hold_q >= REL_LAST && (!ht || lock_clear_ack))
                        state_d = ST_NORMAL;
                end
            endcase
        end

        // Counters restart on any state change so each dwell is measured from entry.
        if (clear && state_d == state_q)
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
        else
            hold_d = '0;

        if (state_q == ST_STALL && state_d == ST_STALL)
            stall_d = (stall_q == STALL_LAST) ? stall_q : stall_q + 1'b1;
        else
            stall_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
            hold_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stall_q <= stall_d;
        end
    end

    assign state      = state_q;
    assign state_next = state_d;

endmodule

// File: rtl/fsm_entropy_overlay_mc.sv
// Multi-channel entropy overlay: per-channel controllers plus lock quorum, max-score tracking and event counters.
module fsm_entropy_overlay_mc
    import entropy_overlay_pkg::*;
#(
    parameter int NUM_CH              = 4,
    parameter int ENT_W               = 8,
    parameter int HOLD_CYCLES         = 4,
    parameter int STALL_TIMEOUT       = 32,
    parameter int LOCK_RELEASE_CYCLES = 16,
    parameter int LOCK_QUORUM         = 2,
    localparam int CH_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*NUM_CH-1:0]     ml_predicted_action,
    input  logic [ENT_W*NUM_CH-1:0] entropy_score,
    input  logic [NUM_CH-1:0]       hazard_flag,
    input  logic [2*NUM_CH-1:0]     classified_entropy_level,
    input  logic [3*NUM_CH-1:0]     instr_type,
    input  logic [NUM_CH-1:0]       shock_detected,
    input  logic                    quantum_override,
    input  logic                    analog_lock_override,
    input  logic                    analog_flush_override,
    input  logic                    override_auth_valid,
    input  logic [1:0]              mission_profile,
    input  logic [ENT_W-1:0]        entropy_threshold,
    input  logic                    lock_clear_ack,
    output logic [2*NUM_CH-1:0]     fsm_state,
    output logic                    global_lock,
    output logic [ENT_W-1:0]        max_entropy_out,
    output logic [CH_W-1:0]         max_entropy_ch,
    output logic [15:0]             lock_event_count,
    output logic [7:0]              auth_fail_count
);

    ovl_state_e ch_state [NUM_CH];
    ovl_state_e ch_next  [NUM_CH];
    logic       lock_req, flush_req;

    assign lock_req  = override_auth_valid && analog_lock_override;
    assign flush_req = override_auth_valid && analog_flush_override;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        entropy_overlay_channel #(
            .ENT_W              (ENT_W),
            .HOLD_CYCLES        (HOLD_CYCLES),
            .STALL_TIMEOUT      (STALL_TIMEOUT),
            .LOCK_RELEASE_CYCLES(LOCK_RELEASE_CYCLES)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .ml_action       (ml_predicted_action[2*g +: 2]),
            .score           (entropy_score[ENT_W*g +: ENT_W]),
            .hazard          (hazard_flag[g]),
            .level           (classified_entropy_level[2*g +: 2]),
            .itype           (instr_type[3*g +: 3]),
            .shock           (shock_detected[g]),
            .quantum_override(quantum_override),
            .lock_req        (lock_req),
            .flush_req       (flush_req),
            .mission         (mission_profile),
            .threshold       (entropy_threshold),
            .lock_clear_ack  (lock_clear_ack),
            .global_lock     (global_lock),
            .state           (ch_state[g]),
            .state_next      (ch_next[g])
        );
        assign fsm_state[2*g +: 2] = ch_state[g];
    end

    int               n_locked, n_enter;
    logic [31:0]      evt_sum;
    logic [15:0]      lock_evt_d;
    logic [7:0]       auth_fail_d;
    logic [ENT_W-1:0] best_val_p0;
    logic [CH_W-1:0]  best_idx_p0;

    always_comb begin
        n_locked = 0;
        n_enter  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_state[i] == ST_LOCK)
                n_locked++;
            if (ch_state[i] != ST_LOCK && ch_next[i] == ST_LOCK)
                n_enter++;
        end
        evt_sum    = {16'b0, lock_event_count} + n_enter;
        lock_evt_d = (evt_sum > 32'h0000_FFFF) ? 16'hFFFF : evt_sum[15:0];

        auth_fail_d = auth_fail_count;
        if ((analog_lock_override || analog_flush_override) && !override_auth_valid && auth_fail_count != 8'hFF)
            auth_fail_d = auth_fail_count + 8'd1;

        // Strict comparison keeps the lowest index on ties.
        best_val_p0 = entropy_score[ENT_W-1:0];
        best_idx_p0 = '0;
        for (int i = 1; i < NUM_CH; i++) begin
            if (entropy_score[ENT_W*i +: ENT_W] > best_val_p0) begin
                best_val_p0 = entropy_score[ENT_W*i +: ENT_W];
                best_idx_p0 = CH_W'(i);
            end
        end
    end

    // Stage p0 -> registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            global_lock      <= 1'b0;
            lock_event_count <= '0;
            auth_fail_count  <= '0;
            max_entropy_out  <= '0;
            max_entropy_ch   <= '0;
        end else begin
            global_lock      <= (n_locked >= LOCK_QUORUM);
            lock_event_count <= lock_evt_d;
            auth_fail_count  <= auth_fail_d;
            max_entropy_out  <= best_val_p0;
            max_entropy_ch   <= best_idx_p0;
        end
    end

endmodule

// File: tb/tb_fsm_entropy_overlay_mc.sv
// Directed bench for fsm_entropy_overlay_mc with hand-computed expectations.
module tb_fsm_entropy_overlay_mc;

    localparam int NUM_CH = 4;
    localparam int ENT_W  = 8;

    logic                    clk;
    logic                    rst_n;
    logic [2*NUM_CH-1:0]     ml;
    logic [ENT_W*NUM_CH-1:0] ent;
    logic [NUM_CH-1:0]       haz;
    logic [2*NUM_CH-1:0]     lvl;
    logic [3*NUM_CH-1:0]     itype;
    logic [NUM_CH-1:0]       shock;
    logic                    qo, alo, afo, auth, ack;
    logic [1:0]              mission;
    logic [ENT_W-1:0]        thr;
    logic [2*NUM_CH-1:0]     fsm_state;
    logic                    global_lock;
    logic [ENT_W-1:0]        max_out;
    logic [1:0]              max_ch;
    logic [15:0]             lec;
    logic [7:0]              afc;

    int checks   = 0;
    int failures = 0;

    fsm_entropy_overlay_mc #(
        .NUM_CH(NUM_CH), .ENT_W(ENT_W), .HOLD_CYCLES(4), .STALL_TIMEOUT(32),
        .LOCK_RELEASE_CYCLES(16), .LOCK_QUORUM(2)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .ml_predicted_action     (ml),
        .entropy_score           (ent),
        .hazard_flag             (haz),
        .classified_entropy_level(lvl),
        .instr_type              (itype),
        .shock_detected          (shock),
        .quantum_override        (qo),
        .analog_lock_override    (alo),
        .analog_flush_override   (afo),
        .override_auth_valid     (auth),
        .mission_profile         (mission),
        .entropy_threshold       (thr),
        .lock_clear_ack          (ack),
        .fsm_state               (fsm_state),
        .global_lock             (global_lock),
        .max_entropy_out         (max_out),
        .max_entropy_ch          (max_ch),
        .lock_event_count        (lec),
        .auth_fail_count         (afc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ml = '0; ent = '0; haz = '0; lvl = '0; itype = '0; shock = '0;
        qo = 1'b0; alo = 1'b0; afo = 1'b0; auth = 1'b0; ack = 1'b0;
        mission = 2'b00; thr = 8'hFF;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step(2);
        chk("reset_state", 32'(fsm_state), 'h00);
        chk("reset_glock", 32'(global_lock), 'h0);
        chk("reset_lec", 32'(lec), 'h0);
        chk("reset_afc", 32'(afc), 'h0);
        chk("reset_max", 32'(max_out), 'h0);
        rst_n = 1'b1;

        // Single-cycle hazard on ch0, then hold-off back to NORMAL.
        haz = 4'b0001;
        step(1);
        chk("haz_stall", 32'(fsm_state), 'h01);
        haz = '0;
        step(3);
        chk("hold_3clear", 32'(fsm_state), 'h01);
        step(1);
        chk("hold_4clear", 32'(fsm_state), 'h00);

        // Continuous hazard on ch1: timeout escalation after 32 STALL cycles.
        haz = 4'b0010;
        step(1);
        chk("ch1_stall", 32'(fsm_state), 'h04);
        step(31);
        chk("stall_31", 32'(fsm_state), 'h04);
        step(1);
        chk("stall_timeout", 32'(fsm_state), 'h08);
        step(7);
        chk("flush_hold_haz", 32'(fsm_state), 'h08);
        haz = '0;
        step(4);
        chk("flush_exit", 32'(fsm_state), 'h00);

        // Score above threshold in NORMAL mission stalls.
        thr = 8'h40; ent = 32'h0000_0041;
        step(1);
        chk("thr_stall", 32'(fsm_state), 'h01);
        thr = 8'hFF; ent = '0;
        step(4);
        chk("thr_exit", 32'(fsm_state), 'h00);

        // DIAGNOSTIC: critical level flushes instead of locking.
        mission = 2'b10; lvl = 8'h02;
        step(1);
        chk("diag_crit", 32'(fsm_state), 'h02);
        lvl = '0; mission = 2'b00;
        step(4);
        chk("diag_exit", 32'(fsm_state), 'h00);

        // HIGH_THREAT lock needs ack; early ack is not remembered.
        mission = 2'b01; lvl = 8'h02;
        step(1);
        chk("ht_crit_lock", 32'(fsm_state), 'h03);
        lvl = '0; ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("ht_early_ack", 32'(fsm_state), 'h03);
        step(20);
        chk("ht_no_ack", 32'(fsm_state), 'h03);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("ht_ack_exit", 32'(fsm_state), 'h00);

        // NORMAL mission auto-release after 16 clear cycles.
        mission = 2'b00; ml = 8'h03;
        step(1);
        chk("nm_lock", 32'(fsm_state), 'h03);
        ml = '0;
        step(15);
        chk("nm_lock_15", 32'(fsm_state), 'h03);
        step(1);
        chk("nm_release", 32'(fsm_state), 'h00);
        chk("nm_lec", 32'(lec), 'h2);

        // Quorum: two locks pull the remaining channels into LOCK.
        do_reset();
        ml = 8'h33;
        step(1);
        chk("q_two_lock", 32'(fsm_state), 'h33);
        chk("q_glock_lat", 32'(global_lock), 'h0);
        ml = '0;
        step(1);
        chk("q_glock", 32'(global_lock), 'h1);
        chk("q_hold_two", 32'(fsm_state), 'h33);
        step(1);
        chk("q_all_lock", 32'(fsm_state), 'hFF);
        chk("q_lec", 32'(lec), 'h4);

        // Unauthenticated override only counts.
        do_reset();
        alo = 1'b1;
        step(200);
        chk("af_200", 32'(afc), 'd200);
        chk("af_no_effect", 32'(fsm_state), 'h00);
        step(100);
        chk("af_sat", 32'(afc), 'd255);
        chk("af_no_effect2", 32'(fsm_state), 'h00);
        auth = 1'b1;
        step(1);
        chk("auth_lock", 32'(fsm_state), 'hFF);
        chk("auth_lec", 32'(lec), 'h4);
        chk("auth_afc_hold", 32'(afc), 'd255);

        // Max-score tracking and asynchronous abort from LOCK.
        do_reset();
        ent = 32'h0580_8010;
        step(1);
        chk("max_val_tie", 32'(max_out), 'h80);
        chk("max_ch_tie", 32'(max_ch), 'h1);
        ent = 32'hF020_3040;
        step(1);
        chk("max_val_top", 32'(max_out), 'hF0);
        chk("max_ch_top", 32'(max_ch), 'h3);
        ent = 32'h0707_0707;
        qo = 1'b1;
        step(1);
        chk("max_ch_eq", 32'(max_ch), 'h0);
        chk("qo_lock", 32'(fsm_state), 'hFF);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(fsm_state), 'h00);
        chk("arst_glock", 32'(global_lock), 'h0);
        chk("arst_lec", 32'(lec), 'h0);
        chk("arst_max", 32'(max_out), 'h0);
        chk("arst_max_ch", 32'(max_ch), 'h0);
        rst_n = 1'b1;
        idle();
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
